// File: rtl/rv32_d_regfile_mp.sv
// Parametrised multi-port register file with clear engine and write bypass.
// Ports: clk_i, rst_ni, clear_req_i, clear_busy_o, we_i/waddr_i/wdata_i, raddr_i/rdata_o.
module rv32_d_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_req_i,
  output logic                     clear_busy_o,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     waddr_i,
  input  logic [NUM_WR*XLEN-1:0]   wdata_i,
  input  logic [NUM_RD*AW-1:0]     raddr_i,
  output logic [NUM_RD*XLEN-1:0]   rdata_o
);

  localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic            busy;

  assign busy         = (state_q == CLEAR);
  assign clear_busy_o = busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          cnt_d   = FIRST;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage has no reset; the clear engine zeroes it row by row.
  // Row 0 is never written when ZERO_REG is set and is trimmed away.
  // Later write ports overwrite earlier ones on an address collision.
  always_ff @(posedge clk_i) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we_i[k] &&
            (ZERO_REG == 0 || waddr_i[k*AW +: AW] != '0)) begin
          mem_q[waddr_i[k*AW +: AW]] <= wdata_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      ra = raddr_i[j*AW +: AW];
      rd = mem_q[ra];
      if (BYPASS != 0 && !busy) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (we_i[k] && waddr_i[k*AW +: AW] == ra)
            rd = wdata_i[k*XLEN +: XLEN];
        end
      end
      if (ZERO_REG != 0 && ra == '0) rd = '0;
      rdata_o[j*XLEN +: XLEN] = rd;
    end
  end

endmodule

// File: tb/tb_rv32_d_regfile_mp.sv
// Directed bench for rv32_d_regfile_mp: a 2-write bypassing instance and
// a 16-deep non-bypassing instance without a hardwired zero register.
module tb_rv32_d_regfile_mp;

  logic clk;
  logic rst_n;

  logic        creq_a, busy_a;
  logic [1:0]  we_a;
  logic [9:0]  waddr_a;
  logic [63:0] wdata_a;
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;

  logic        creq_b, busy_b;
  logic [0:0]  we_b;
  logic [3:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [7:0]  raddr_b;
  logic [63:0] rdata_b;

  int tests;
  int fails;
  int na, nb, n;

  rv32_d_regfile_mp #(
    .NUM_WR(2)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_req_i (creq_a),
    .clear_busy_o(busy_a),
    .we_i        (we_a),
    .waddr_i     (waddr_a),
    .wdata_i     (wdata_a),
    .raddr_i     (raddr_a),
    .rdata_o     (rdata_a)
  );

  rv32_d_regfile_mp #(
    .DEPTH   (16),
    .ZERO_REG(0),
    .BYPASS  (0)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_req_i (creq_b),
    .clear_busy_o(busy_b),
    .we_i        (we_b),
    .waddr_i     (waddr_b),
    .wdata_i     (wdata_b),
    .raddr_i     (raddr_b),
    .rdata_o     (rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic count_busy(output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (!busy_a && ca == 0) ca = i;
      if (!busy_b && cb == 0) cb = i;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    creq_a = 0; we_a = '0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
    creq_b = 0; we_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
    tick();
    tick();
    chk("rst_busy_a", {31'd0, busy_a}, 32'd1);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd1);
    chk("rst_x0_a", rdata_a[31:0], 32'h0);
    rst_n = 1'b1;
    count_busy(na, nb);
    chk("clr_len_a", na, 32'd31);
    chk("clr_len_b", nb, 32'd16);

    for (int a = 0; a < 32; a++) begin
      raddr_a[4:0] = a[4:0];
      #1;
      chk($sformatf("init_a_x%0d", a), rdata_a[31:0], 32'h0);
    end
    for (int a = 0; a < 16; a++) begin
      raddr_b[3:0] = a[3:0];
      #1;
      chk($sformatf("init_b_x%0d", a), rdata_b[31:0], 32'h0);
    end

    // Bypass on A: read port 1 sees the write before the edge.
    we_a = 2'b01; waddr_a[4:0] = 5'd5; wdata_a[31:0] = 32'hDEAD_BEEF;
    raddr_a[9:5] = 5'd5;
    #1;
    chk("byp_a_pre", rdata_a[63:32], 32'hDEAD_BEEF);
    tick();
    we_a = '0;
    #1;
    chk("byp_a_post", rdata_a[63:32], 32'hDEAD_BEEF);

    // No bypass on B: old value before the edge, new after.
    we_b = 1'b1; waddr_b = 4'd5; wdata_b = 32'hDEAD_BEEF;
    raddr_b[3:0] = 4'd5;
    #1;
    chk("nobyp_b_pre", rdata_b[31:0], 32'h0);
    tick();
    we_b = '0;
    #1;
    chk("nobyp_b_post", rdata_b[31:0], 32'hDEAD_BEEF);

    // B row 0 is a real register.
    we_b = 1'b1; waddr_b = 4'd0; wdata_b = 32'hA5A5_A5A5;
    tick();
    we_b = '0;
    raddr_b[7:4] = 4'd0;
    #1;
    chk("b_x0_written", rdata_b[63:32], 32'hA5A5_A5A5);

    // x0 hardwired on A, including the bypass cycle.
    we_a = 2'b01; waddr_a[4:0] = 5'd0; wdata_a[31:0] = 32'hFFFF_FFFF;
    raddr_a[4:0] = 5'd0;
    #1;
    chk("x0_byp", rdata_a[31:0], 32'h0);
    tick();
    we_a = '0;
    #1;
    chk("x0_after", rdata_a[31:0], 32'h0);

    // Both ports write x7: port 1 wins for storage and bypass.
    we_a = 2'b11;
    waddr_a = {5'd7, 5'd7};
    wdata_a = {32'h2222_2222, 32'h1111_1111};
    raddr_a[4:0] = 5'd7;
    #1;
    chk("dual_byp", rdata_a[31:0], 32'h2222_2222);
    tick();
    we_a = '0;
    #1;
    chk("dual_store", rdata_a[31:0], 32'h2222_2222);

    // Port 0 alone bypasses when port 1 writes elsewhere.
    we_a = 2'b11;
    waddr_a = {5'd9, 5'd8};
    wdata_a = {32'h9999_9999, 32'h8888_8888};
    raddr_a = {5'd9, 5'd8};
    #1;
    chk("split_byp0", rdata_a[31:0], 32'h8888_8888);
    chk("split_byp1", rdata_a[63:32], 32'h9999_9999);
    tick();
    we_a = '0;

    // Preload x3 and x4, then request a clear.
    we_a = 2'b11;
    waddr_a = {5'd4, 5'd3};
    wdata_a = {32'h5555_5555, 32'h1234_5678};
    tick();
    we_a = '0;
    raddr_a = {5'd4, 5'd3};
    #1;
    chk("x3_loaded", rdata_a[31:0], 32'h1234_5678);
    creq_a = 1'b1;
    tick();
    creq_a = 1'b0;
    chk("clr_busy", {31'd0, busy_a}, 32'd1);
    we_a = 2'b01; waddr_a[4:0] = 5'd4; wdata_a[31:0] = 32'hCAFE_F00D;
    #1;
    chk("clr_no_byp", rdata_a[63:32], 32'h5555_5555);
    tick();
    n = 1;
    we_a = '0;
    #1;
    chk("clr_wr_drop", rdata_a[63:32], 32'h5555_5555);
    repeat (9) begin
      tick();
      n++;
    end
    creq_a = 1'b1;
    tick();
    n++;
    creq_a = 1'b0;
    while (busy_a && n < 100) begin
      tick();
      n++;
    end
    chk("clr_req_len", n, 32'd31);
    #1;
    chk("x3_cleared", rdata_a[31:0], 32'h0);
    chk("x4_cleared", rdata_a[63:32], 32'h0);

    // Reset at clear cycle 10 restarts the full sweep.
    creq_a = 1'b1;
    tick();
    creq_a = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_a", {31'd0, busy_a}, 32'd1);
    chk("mid_rst_busy_b", {31'd0, busy_b}, 32'd1);
    tick();
    rst_n = 1'b1;
    count_busy(na, nb);
    chk("rst_len_a", na, 32'd31);
    chk("rst_len_b", nb, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
